// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: five-stage pipeline sequencer for load-use stalls, branch redirects, dmem freezes and debug halt
module pipe_hazard_ctrl #(
  parameter int WIDTH = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_branch_taken,
  input  logic [WIDTH-3:0] ex_branch_target,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             dmem_busy,
  input  logic             halt_req,
  input  logic             resume,
  output logic             is_stall,
  output logic             is_branch,
  output logic [WIDTH-3:0] branch_addr,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             freeze,
  output logic             halted,
  output logic [15:0]      stall_cnt
);
  typedef enum logic [2:0] {RUN, LOAD_STALL, REDIRECT, DRAIN, HALTED} state_t;
  state_t state_q, state_d;
  logic [3:0] drain_q, drain_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic load_use;
  assign load_use = ex_is_load && ex_rd != 5'd0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    is_stall = 1'b0;
    is_branch = 1'b0;
    flush_id = 1'b0;
    bubble_ex = 1'b0;
    freeze = 1'b0;
    halted = 1'b0;
    if (!rst_n) begin
      state_d = RUN;
    end else if (dmem_busy) begin
      freeze = 1'b1;
      is_stall = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            is_branch = 1'b1;
            flush_id = 1'b1;
            bubble_ex = 1'b1;
            state_d = REDIRECT;
          end else if (load_use) begin
            is_stall = 1'b1;
            bubble_ex = 1'b1;
            state_d = LOAD_STALL;
          end else if (halt_req) begin
            is_stall = 1'b1;
            bubble_ex = 1'b1;
            drain_d = 4'(DRAIN_CYCLES - 1);
            state_d = DRAIN;
          end
        end
        LOAD_STALL: state_d = RUN;
        REDIRECT: begin
          flush_id = 1'b1;
          state_d = RUN;
        end
        DRAIN: begin
          is_stall = 1'b1;
          bubble_ex = 1'b1;
          state_d = drain_q == 4'd0 ? HALTED : DRAIN;
          drain_d = drain_q == 4'd0 ? drain_q : drain_q - 4'd1;
        end
        HALTED: begin
          is_stall = 1'b1;
          bubble_ex = 1'b1;
          halted = 1'b1;
          state_d = resume ? RUN : HALTED;
        end
        default: state_d = RUN;
      endcase
    end
  end
  assign branch_addr = is_branch ? ex_branch_target : '0;
  assign stall_cnt_d = (is_stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  assign stall_cnt = stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic ex_branch_taken;
  logic [29:0] ex_branch_target;
  logic ex_is_load;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic id_use_rs1, id_use_rs2, dmem_busy, halt_req, resume;
  logic is_stall, is_branch, flush_id, bubble_ex, freeze, halted;
  logic [29:0] branch_addr;
  logic [15:0] stall_cnt;
  logic [5:0] outs;
  int n_chk = 0;
  int n_fail = 0;
  assign outs = {is_stall, is_branch, flush_id, bubble_ex, freeze, halted};
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.WIDTH(32), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .dmem_busy(dmem_busy),
    .halt_req(halt_req), .resume(resume), .is_stall(is_stall), .is_branch(is_branch),
    .branch_addr(branch_addr), .flush_id(flush_id), .bubble_ex(bubble_ex),
    .freeze(freeze), .halted(halted), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    ex_branch_taken = 1'b0;
    ex_branch_target = '0;
    ex_is_load = 1'b0;
    ex_rd = '0;
    id_rs1 = '0;
    id_rs2 = '0;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    dmem_busy = 1'b0;
    halt_req = 1'b0;
    resume = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    idle();
    dmem_busy = 1'b1;
    halt_req = 1'b1;
    tick();
    tick();
    settle();
    chk("reset_outs", 32'(outs), 32'h0);
    chk("reset_cnt", 32'(stall_cnt), 32'h0);
    idle();
    rst_n = 1'b1;
    tick();
    settle();
    chk("idle_outs", 32'(outs), 32'h0);
    chk("idle_cnt", 32'(stall_cnt), 32'h0);
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    settle();
    chk("lu_rs1_c0", 32'(outs), 32'b100100);
    tick();
    idle();
    settle();
    chk("lu_rs1_c1", 32'(outs), 32'h0);
    chk("lu_rs1_cnt", 32'(stall_cnt), 32'd1);
    tick();
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    settle();
    chk("lu_rd0", 32'(outs), 32'h0);
    ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
    settle();
    chk("lu_nouse", 32'(outs), 32'h0);
    idle();
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    settle();
    chk("lu_rs2_c0", 32'(outs), 32'b100100);
    tick();
    idle();
    settle();
    chk("lu_rs2_c1", 32'(outs), 32'h0);
    chk("lu_rs2_cnt", 32'(stall_cnt), 32'd2);
    tick();
    ex_branch_taken = 1'b1; ex_branch_target = 30'h40;
    settle();
    chk("br_c0", 32'(outs), 32'b011100);
    chk("br_addr", 32'(branch_addr), 32'h40);
    tick();
    idle();
    settle();
    chk("br_c1", 32'(outs), 32'b001000);
    chk("br_c1_addr", 32'(branch_addr), 32'h0);
    tick();
    settle();
    chk("br_c2", 32'(outs), 32'h0);
    ex_branch_taken = 1'b1; ex_branch_target = 30'h88;
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    settle();
    chk("brlu_c0", 32'(outs), 32'b011100);
    chk("brlu_addr", 32'(branch_addr), 32'h88);
    tick();
    idle();
    settle();
    chk("brlu_c1", 32'(outs), 32'b001000);
    tick();
    settle();
    chk("brlu_c2", 32'(outs), 32'h0);
    chk("brlu_cnt", 32'(stall_cnt), 32'd2);
    ex_branch_taken = 1'b1; ex_branch_target = 30'h10; halt_req = 1'b1;
    settle();
    chk("brh_c0", 32'(outs), 32'b011100);
    tick();
    ex_branch_taken = 1'b0;
    settle();
    chk("brh_redirect", 32'(outs), 32'b001000);
    tick();
    settle();
    chk("halt_accept", 32'(outs), 32'b100100);
    for (int i = 1; i <= 3; i++) begin
      tick();
      settle();
      chk($sformatf("drain_%0d", i), 32'(outs), 32'b100100);
    end
    tick();
    settle();
    chk("halted", 32'(outs), 32'b100101);
    chk("halt_cnt", 32'(stall_cnt), 32'd6);
    halt_req = 1'b0; resume = 1'b1;
    settle();
    chk("resume_c0", 32'(outs), 32'b100101);
    tick();
    resume = 1'b0;
    settle();
    chk("resume_c1", 32'(outs), 32'h0);
    chk("resume_cnt", 32'(stall_cnt), 32'd7);
    ex_branch_taken = 1'b1; ex_branch_target = 30'h123; dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("busy_%0d", i), 32'(outs), 32'b100010);
      chk($sformatf("busy_addr_%0d", i), 32'(branch_addr), 32'h0);
      tick();
    end
    dmem_busy = 1'b0;
    settle();
    chk("busy_br_fire", 32'(outs), 32'b011100);
    chk("busy_br_addr", 32'(branch_addr), 32'h123);
    chk("busy_cnt", 32'(stall_cnt), 32'd11);
    tick();
    ex_branch_taken = 1'b0;
    settle();
    chk("busy_redirect", 32'(outs), 32'b001000);
    tick();
    halt_req = 1'b1;
    settle();
    chk("h2_accept", 32'(outs), 32'b100100);
    tick();
    dmem_busy = 1'b1;
    settle();
    chk("h2_frz_a", 32'(outs), 32'b100010);
    tick();
    settle();
    chk("h2_frz_b", 32'(outs), 32'b100010);
    tick();
    dmem_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("h2_drain_%0d", i), 32'(outs), 32'b100100);
      tick();
    end
    settle();
    chk("h2_halted", 32'(outs), 32'b100101);
    repeat (66000) tick();
    settle();
    chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    chk("sat_halted", 32'(outs), 32'b100101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", 32'(outs), 32'h0);
    chk("rst_async_cnt", 32'(stall_cnt), 32'h0);
    halt_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    chk("post_rst_outs", 32'(outs), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage core. It drives the fetch stage's stall and branch-redirect inputs, and the ID flush and EX bubble-insert controls. It resolves load-use hazards, taken branches from EX, data-memory wait freezes and debug halt/resume. It sits beside the pipeline registers and is the only source of IsStall, IsBranch and BranchAddr into the fetch stage.

## Interface
- WIDTH, 32, datapath width; instruction addresses are WIDTH-2 bits (word-aligned, low 2 bits implied 0)
- DRAIN_CYCLES, 3, cycles of EX bubbles after a halt is accepted before `halted` asserts (1..15)
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  reset, asynchronous, active-low
- ex_branch_taken  input  1  branch/jump in EX resolved taken this cycle
- ex_branch_target  input  WIDTH-2  target address of the EX branch
- ex_is_load  input  1  instruction in EX is a load
- ex_rd  input  5  destination register of the EX instruction
- id_rs1, id_rs2  input  5 each  source registers of the ID instruction
- id_use_rs1, id_use_rs2  input  1 each  ID instruction actually reads rs1/rs2
- dmem_busy  input  1  data memory not ready; whole pipeline must freeze
- halt_req  input  1  debug halt request, level
- resume  input  1  debug resume, single-cycle pulse
- is_stall  output  1  to fetch IsStall: hold PC and IR
- is_branch  output  1  to fetch IsBranch: load PC from branch_addr
- branch_addr  output  WIDTH-2  to fetch BranchAddr
- flush_id  output  1  replace IF/ID contents with NOP at next edge
- bubble_ex  output  1  insert NOP into ID/EX at next edge
- freeze  output  1  hold every pipeline register (ID/EX, EX/MEM, MEM/WB)
- halted  output  1  core halted and drained
- stall_cnt  output  16  saturating count of cycles with is_stall=1

## Operation
- States: RUN, LOAD_STALL, REDIRECT, DRAIN, HALTED. The state register and counters are sequential. All control outputs are combinational from state and current inputs.
- load_use = ex_is_load && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- Global rule, any state: dmem_busy=1 forces freeze=1 and is_stall=1; is_branch, flush_id and bubble_ex are 0. The state does not change and the DRAIN counter holds. This rule has priority over everything except reset.
- RUN, with dmem_busy=0, priority order:
  - ex_branch_taken: is_branch=1, branch_addr=ex_branch_target, flush_id=1, bubble_ex=1; next state REDIRECT.
  - else load_use: is_stall=1, bubble_ex=1; next state LOAD_STALL.
  - else halt_req: is_stall=1, bubble_ex=1, drain counter loaded with DRAIN_CYCLES-1; next state DRAIN.
  - else all outputs 0; stay in RUN.
- LOAD_STALL: exactly one cycle. Outputs 0, which releases fetch. Branch and load_use are ignored because EX holds a bubble. Next state RUN.
- REDIRECT: exactly one cycle. flush_id=1 to kill the wrong-path word fetched at the branch edge. is_stall=0. EX inputs are ignored. Next state RUN.
- DRAIN: is_stall=1 and bubble_ex=1. The counter decrements each unfrozen cycle. At count 0, next state HALTED. EX branches are ignored, because only bubbles enter EX after acceptance.
- HALTED: is_stall=1, halted=1, bubble_ex=1. On resume=1 the next state is RUN. A resume in any other state is ignored. halt_req is level, so if it is still high after resume, the halt re-enters.
- branch_addr equals ex_branch_target whenever is_branch=1; otherwise it is 0.
- stall_cnt increments on each posedge where is_stall=1, saturating at 16'hFFFF.

## Timing
- Reset (rst_n low, asynchronous): state=RUN, drain counter=0, stall_cnt=0. All outputs are forced to 0 while reset is asserted, regardless of inputs.
- A redirect takes effect at the posedge where is_branch=1. The branch penalty is 2 cycles: the flushed ID slot plus the REDIRECT flush.
- A load-use hazard costs exactly 1 stall cycle.
- From halt acceptance to halted=1 is DRAIN_CYCLES+1 cycles, excluding frozen cycles. halted drops the cycle after resume is sampled.
- Simultaneous branch and load_use in RUN: the branch wins, and the load-use is discarded because ID is flushed.
- Simultaneous branch and halt_req: the branch is taken first; the halt is accepted the first RUN cycle after REDIRECT.
- dmem_busy in the same cycle as a branch: the freeze wins and the branch is re-evaluated once dmem_busy falls. EX is held, so ex_branch_taken persists.
- Reset mid-DRAIN or mid-HALTED returns the block to RUN with halted=0.

## Test plan
- Reset, then RUN with idle inputs: all outputs 0 and stall_cnt=0. Assert rst_n=0 in the middle of a stall: outputs drop to 0 immediately, without waiting for a clock edge.
- ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle: is_stall=1 and bubble_ex=1 for 1 cycle, then 0; stall_cnt=1. Repeat with ex_rd=0: no stall.
- ex_branch_taken=1, target=30'h40 for one cycle: is_branch=1, branch_addr=30'h40, flush_id=1 and bubble_ex=1 in cycle 0; flush_id=1 only in cycle 1; idle in cycle 2.
- Branch and load_use together: only the branch response occurs; no stall cycle is added.
- dmem_busy high for 4 cycles during a branch: freeze=1, is_stall=1 and is_branch=0 for 4 cycles; the branch fires in cycle 5; stall_cnt=4.
- halt_req=1 with DRAIN_CYCLES=3: halted=1 on the 4th cycle after acceptance. resume pulse with halt_req=0: halted=0 and is_stall=0 the next cycle. Also check stall_cnt saturates at 16'hFFFF.
